mem_access: RTL

//   MEM stage of the 5-stage RISC-V pipeline; sits between the EX/MEM register and the MEM/WB register.

---
 rtl/mem_access_pkg.sv | 44 ++++
 rtl/mem_access_load_extend.sv | 23 ++
 rtl/mem_access.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: op encodings, NOP constants, FSM states
// and per-op helpers used by the byte-serial access engine.
package mem_access_pkg;

    localparam int MemOpBus = 4;

    localparam logic [MemOpBus-1:0] MEM_NOP = 4'd0;
    localparam logic [MemOpBus-1:0] MEM_LB  = 4'd1;
    localparam logic [MemOpBus-1:0] MEM_LH  = 4'd2;
    localparam logic [MemOpBus-1:0] MEM_LW  = 4'd3;
    localparam logic [MemOpBus-1:0] MEM_LBU = 4'd4;
    localparam logic [MemOpBus-1:0] MEM_LHU = 4'd5;
    localparam logic [MemOpBus-1:0] MEM_SB  = 4'd6;
    localparam logic [MemOpBus-1:0] MEM_SH  = 4'd7;
    localparam logic [MemOpBus-1:0] MEM_SW  = 4'd8;

    localparam logic [4:0]  NOPAddr  = 5'd0;
    localparam logic [31:0] ZeroWord = 32'd0;
    localparam logic        True     = 1'b1;
    localparam logic        False    = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } mem_state_e;

    function automatic logic is_store(input logic [MemOpBus-1:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Index of the final byte of an access (bytes per access minus one).
    function automatic logic [1:0] last_idx(input logic [MemOpBus-1:0] op);
        logic [1:0] idx;
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: idx = 2'd0;
            MEM_LH, MEM_LHU, MEM_SH: idx = 2'd1;
            default:                 idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Combinational load formatter: turns the little-endian byte buffer into the
// register write value, sign- or zero-extending byte and halfword loads.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0]         buf_i,
    input  logic [MemOpBus-1:0] op_i,
    output logic [31:0]         data_o
);

    always_comb begin
        data_o = ZeroWord;
        case (op_i)
            MEM_LB:  data_o = {{24{buf_i[7]}}, buf_i[7:0]};
            MEM_LBU: data_o = {24'd0, buf_i[7:0]};
            MEM_LH:  data_o = {{16{buf_i[15]}}, buf_i[15:0]};
            MEM_LHU: data_o = {16'd0, buf_i[15:0]};
            MEM_LW:  data_o = buf_i;
            default: data_o = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: runs loads/stores one byte at a time over the 8-bit
// arbiter port, stalling the pipeline until the result is ready.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_clear,
    input  logic                stall_in,
    input  logic [4:0]          ex_wd,
    input  logic                ex_wreg,
    input  logic [31:0]         ex_wdata,
    input  logic [MemOpBus-1:0] ex_mem_op,
    input  logic [ADDR_W-1:0]   ex_mem_addr,
    input  logic [31:0]         ex_mem_sdata,
    input  logic                mem_gnt,
    input  logic [7:0]          mem_rbyte,
    output logic                mem_req,
    output logic                mem_rw,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [7:0]          mem_wbyte,
    output logic                stall_req,
    output logic [4:0]          mem_wd,
    output logic                mem_wreg,
    output logic [31:0]         mem_wdata
);

    mem_state_e          state_q, state_d;
    logic [1:0]          k_q, k_d;
    logic                rd_pend_q, rd_pend_d;
    logic [1:0]          rd_idx_q, rd_idx_d;
    logic                start;
    logic                flush;

    logic [MemOpBus-1:0] op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         sdata_q;
    logic [4:0]          wd_q;
    logic                wreg_q;
    logic [31:0]         buf_q;
    logic [31:0]         ext_data;

    assign flush = mem_clear | rst;

    load_extend u_load_extend (
        .buf_i  (buf_q),
        .op_i   (op_q),
        .data_o (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= 2'd0;
            rd_pend_q <= False;
            rd_idx_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            rd_pend_q <= rd_pend_d;
            rd_idx_q  <= rd_idx_d;
        end
    end

    // A read byte arrives the cycle after its grant; rd_pend/rd_idx remember where it goes.
    always_ff @(posedge clk) begin
        if (start) begin
            op_q    <= ex_mem_op;
            addr_q  <= ex_mem_addr;
            sdata_q <= ex_mem_sdata;
            wd_q    <= ex_wd;
            wreg_q  <= ex_wreg;
            buf_q   <= ZeroWord;
        end else if (rd_pend_q) begin
            buf_q[{rd_idx_q, 3'b000} +: 8] <= mem_rbyte;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        rd_pend_d = False;
        rd_idx_d  = rd_idx_q;
        start     = False;
        mem_req   = False;
        mem_rw    = False;
        mem_addr  = '0;
        mem_wbyte = 8'd0;
        stall_req = False;
        mem_wd    = NOPAddr;
        mem_wreg  = False;
        mem_wdata = ZeroWord;

        case (state_q)
            S_IDLE: begin
                if (ex_mem_op == MEM_NOP) begin
                    mem_wd    = ex_wd;
                    mem_wreg  = ex_wreg;
                    mem_wdata = ex_wdata;
                end else begin
                    stall_req = True;
                    start     = True;
                    state_d   = S_ACCESS;
                    k_d       = 2'd0;
                end
            end
            S_ACCESS: begin
                stall_req = True;
                mem_req   = True;
                mem_rw    = is_store(op_q);
                mem_addr  = addr_q + {{(ADDR_W-2){1'b0}}, k_q};
                mem_wbyte = sdata_q[{k_q, 3'b000} +: 8];
                if (mem_gnt) begin
                    rd_pend_d = !is_store(op_q);
                    rd_idx_d  = k_q;
                    k_d       = k_q + 2'd1;
                    if (k_q == last_idx(op_q)) begin
                        k_d     = 2'd0;
                        state_d = is_store(op_q) ? S_DONE : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall_req = True;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (!is_store(op_q)) begin
                    mem_wd    = wd_q;
                    mem_wreg  = wreg_q;
                    mem_wdata = ext_data;
                end
                if (!stall_in) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over everything, including a grant in the same cycle.
        if (flush) begin
            state_d   = S_IDLE;
            k_d       = 2'd0;
            rd_pend_d = False;
            start     = False;
            mem_req   = False;
            mem_rw    = False;
            mem_addr  = '0;
            mem_wbyte = 8'd0;
            stall_req = False;
            mem_wd    = NOPAddr;
            mem_wreg  = False;
            mem_wdata = ZeroWord;
        end
    end

endmodule
